// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, interrupt cause codes, trap FSM states and mie/mip bit packing
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH = 12'h310;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [4:0] IRQ_CODE_MSI     = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI     = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI     = 5'd11;
  localparam logic [4:0] IRQ_CODE_CUSTOM0 = 5'd16;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_IRQ_PEND = 1'b1
  } trap_state_e;

  // Places the interrupt sources at their mie/mip bit positions; custom
  // sources beyond num_custom are forced to zero.
  function automatic logic [31:0] irq_pad(input logic msi, input logic mti, input logic mei,
                                          input logic [15:0] custom, input int num_custom);
    logic [31:0] v;
    v     = '0;
    v[3]  = msi;
    v[7]  = mti;
    v[11] = mei;
    for (int i = 0; i < 16; i++) begin
      if (i < num_custom) v[16+i] = custom[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - multi-stage flop chain synchroniser for asynchronous interrupt inputs
module irq_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the raw inputs through STAGES flops; the last stage is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/m_trap_ctrl.sv
// rtl/m_trap_ctrl.sv - machine-mode trap controller: CSRs, interrupt arbitration and trap entry/return
module m_trap_ctrl
  import csr_pkg::*;
#(
  parameter int          NUM_CUSTOM_IRQ = 4,
  parameter bit          VECTORED_EN    = 1'b1,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        irq_soft_i,
  input  logic [(NUM_CUSTOM_IRQ > 0 ? NUM_CUSTOM_IRQ : 1)-1:0] irq_custom_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  output logic        trap_valid_o,
  input  logic        trap_ack_i,
  input  logic [31:0] epc_i,
  input  logic        mret_i,
  output logic [31:0] handler_pc_o,
  output logic [31:0] mepc_o
);

  localparam int          CUST_W   = (NUM_CUSTOM_IRQ > 0) ? NUM_CUSTOM_IRQ : 1;
  localparam int          SYNC_W   = CUST_W + 3;
  localparam logic [31:0] MIE_MASK = irq_pad(1'b1, 1'b1, 1'b1, 16'hFFFF, NUM_CUSTOM_IRQ);

  logic [SYNC_W-1:0] sync_q;
  logic [15:0]       custom16;
  logic [31:0]       mip_w;
  logic [31:0]       pending;
  logic              any_pending;
  logic [4:0]        win_code;

  logic              mstatus_mie, mstatus_mpie;
  logic [31:0]       mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic              last_trap_irq;
  logic [4:0]        trap_code_q;

  trap_state_e       state_q, state_d;
  logic [4:0]        cause_q, cause_d;
  logic              irq_entry;

  irq_sync #(.WIDTH(SYNC_W), .STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({irq_custom_i, irq_ext_i, irq_timer_i, irq_soft_i}),
    .q_o   (sync_q)
  );

  // Unpack the synchronised sources into mip bit positions and find the winner.
  always_comb begin
    custom16             = '0;
    custom16[CUST_W-1:0] = sync_q[SYNC_W-1:3];
    mip_w       = irq_pad(sync_q[0], sync_q[1], sync_q[2], custom16, NUM_CUSTOM_IRQ);
    pending     = mip_w & mie_q & {32{mstatus_mie}};
    any_pending = |pending;
    win_code    = IRQ_CODE_MEI;
    if (pending[11])     win_code = IRQ_CODE_MEI;
    else if (pending[3]) win_code = IRQ_CODE_MSI;
    else if (pending[7]) win_code = IRQ_CODE_MTI;
    else begin
      // Descending scan so the lowest pending custom index is the last to assign.
      for (int i = 15; i >= 0; i--) begin
        if (pending[16+i]) win_code = IRQ_CODE_CUSTOM0 + 5'(i);
      end
    end
  end

  // Trap FSM state and frozen interrupt cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state: latch a winner in RUN, wait for ack or a pre-empting exception in IRQ_PEND.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    irq_entry = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!exc_valid_i && any_pending) begin
          state_d = ST_IRQ_PEND;
          cause_d = win_code;
        end
      end
      ST_IRQ_PEND: begin
        if (exc_valid_i) begin
          state_d = ST_RUN;
        end else if (trap_ack_i) begin
          state_d   = ST_RUN;
          irq_entry = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign trap_valid_o = (state_q == ST_IRQ_PEND);

  // CSR state; later statements win, giving exception > ack > mret > software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= {RESET_VECTOR[31:2], 2'b00};
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      last_trap_irq <= 1'b0;
      trap_code_q   <= '0;
    end else begin
      if (csr_we_i) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_wdata_i[3];
            mstatus_mpie <= csr_wdata_i[7];
          end
          CSR_MIE:      mie_q      <= csr_wdata_i & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= {csr_wdata_i[31:2], 1'b0,
                                       VECTORED_EN && (csr_wdata_i[1:0] == 2'b01)};
          CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
          CSR_MEPC:     mepc_q     <= csr_wdata_i & 32'hFFFF_FFFC;
          CSR_MCAUSE:   mcause_q   <= csr_wdata_i;
          CSR_MTVAL:    mtval_q    <= csr_wdata_i;
          default: ;
        endcase
      end
      if (mret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
      if (irq_entry) begin
        mepc_q        <= epc_i & 32'hFFFF_FFFC;
        mcause_q      <= {1'b1, 26'b0, cause_q};
        mtval_q       <= '0;
        mstatus_mpie  <= mstatus_mie;
        mstatus_mie   <= 1'b0;
        last_trap_irq <= 1'b1;
        trap_code_q   <= cause_q;
      end
      if (exc_valid_i) begin
        mepc_q        <= exc_pc_i & 32'hFFFF_FFFC;
        mcause_q      <= {27'b0, exc_code_i};
        mtval_q       <= exc_tval_i;
        mstatus_mpie  <= mstatus_mie;
        mstatus_mie   <= 1'b0;
        last_trap_irq <= 1'b0;
        trap_code_q   <= exc_code_i;
      end
    end
  end

  // Combinational CSR read port and illegal-address decode.
  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS:  csr_rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      CSR_MSTATUSH: csr_rdata_o = '0;
      CSR_MIE:      csr_rdata_o = mie_q;
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MTVAL:    csr_rdata_o = mtval_q;
      CSR_MIP:      csr_rdata_o = mip_w;
      default:      csr_illegal_o = 1'b1;
    endcase
  end

  // Vectored offset only applies to interrupts; exceptions always land on the base.
  always_comb begin
    handler_pc_o = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && last_trap_irq) begin
      handler_pc_o = {mtvec_q[31:2], 2'b00} + {25'b0, trap_code_q, 2'b00};
    end
  end

  assign mepc_o = mepc_q;

endmodule

// File: tb/tb_m_trap_ctrl.sv
// tb/tb_m_trap_ctrl.sv - self-checking bench for m_trap_ctrl
module tb_m_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq_ext_i = 1'b0, irq_timer_i = 1'b0, irq_soft_i = 1'b0;
  logic [3:0]  irq_custom_i = '0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exc_code_i = '0;
  logic [31:0] exc_pc_i = '0, exc_tval_i = '0;
  logic        trap_ack_i = 1'b0;
  logic [31:0] epc_i = '0;
  logic        mret_i = 1'b0;

  logic [31:0] csr_rdata_o, handler_pc_o, mepc_o;
  logic        csr_illegal_o, trap_valid_o;
  logic [31:0] rdata_nv, handler_nv, mepc_nv;
  logic        ill_nv, valid_nv;

  always #5 clk = ~clk;

  m_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .irq_soft_i(irq_soft_i), .irq_custom_i(irq_custom_i), .csr_we_i(csr_we_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i), .trap_valid_o(trap_valid_o),
    .trap_ack_i(trap_ack_i), .epc_i(epc_i), .mret_i(mret_i),
    .handler_pc_o(handler_pc_o), .mepc_o(mepc_o)
  );

  m_trap_ctrl #(.VECTORED_EN(1'b0), .RESET_VECTOR(32'h8000_0103)) dut_nv (
    .clk(clk), .rst_n(rst_n), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .irq_soft_i(irq_soft_i), .irq_custom_i(irq_custom_i), .csr_we_i(csr_we_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(rdata_nv),
    .csr_illegal_o(ill_nv), .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i), .trap_valid_o(valid_nv),
    .trap_ack_i(trap_ack_i), .epc_i(epc_i), .mret_i(mret_i),
    .handler_pc_o(handler_nv), .mepc_o(mepc_nv)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        ill;
    logic        chk_rd;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic sb_push(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=%h required=queued_entry", act);
    end else begin
      e = exp_q.pop_front();
      chk(e.name, act, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i    = 1'b1;
    csr_addr_i  = a;
    csr_wdata_i = d;
    step();
    csr_we_i    = 1'b0;
  endtask

  task automatic csr_rd(input string name, input bit nv, input logic [11:0] a, input logic [31:0] e);
    csr_addr_i = a;
    sb_push(name, e);
    @(negedge clk);
    sb_pop(nv ? rdata_nv : csr_rdata_o);
  endtask

  task automatic do_mret();
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    trap_ack_i = 1'b1;
    epc_i      = pc;
    step();
    trap_ack_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!trap_valid_o && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic add(input string nm, input logic we, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic ill, input logic chk_rd);
    vec_t v;
    v.name = nm; v.we = we; v.addr = a; v.wdata = wd; v.rd = rd; v.ill = ill; v.chk_rd = chk_rd;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    add("rst_mstatus", 1'b0, 12'h300, 32'h0,         32'h0000_1800, 1'b0, 1'b1);
    add("rst_mtvec",   1'b0, 12'h305, 32'h0,         32'h0000_0000, 1'b0, 1'b1);
    add("rst_mie",     1'b0, 12'h304, 32'h0,         32'h0000_0000, 1'b0, 1'b1);
    add("rst_mip",     1'b0, 12'h344, 32'h0,         32'h0000_0000, 1'b0, 1'b1);
    add("mscratch",    1'b1, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    add("mepc_align",  1'b1, 12'h341, 32'h0000_1237, 32'h0000_1234, 1'b0, 1'b1);
    add("mie_mask",    1'b1, 12'h304, 32'hFFFF_FFFF, 32'h000F_0888, 1'b0, 1'b1);
    add("mip_ro",      1'b1, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    add("mstatus_all", 1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0, 1'b1);
    add("mstatush",    1'b1, 12'h310, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    add("mstatus_clr", 1'b1, 12'h300, 32'h0,         32'h0000_1800, 1'b0, 1'b1);
    add("mtvec_mode3", 1'b1, 12'h305, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1);
    add("mtvec_mode2", 1'b1, 12'h305, 32'h0000_1002, 32'h0000_1000, 1'b0, 1'b1);
    add("mtvec_vec",   1'b1, 12'h305, 32'h0000_1001, 32'h0000_1001, 1'b0, 1'b1);
    add("mcause_rw",   1'b1, 12'h342, 32'h8000_000B, 32'h8000_000B, 1'b0, 1'b1);
    add("mtval_rw",    1'b1, 12'h343, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b1);
    add("illegal",     1'b0, 12'h7C0, 32'h0,         32'h0,         1'b1, 1'b0);
    add("mie_clr",     1'b1, 12'h304, 32'h0,         32'h0,         1'b0, 1'b1);

    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk1("rst_valid", trap_valid_o, 1'b0);
    chk("rst_mepc_o", mepc_o, 32'h0);
    csr_rd("nv_rst_mtvec", 1'b1, 12'h305, 32'h8000_0100);

    foreach (tbl[i]) begin
      if (tbl[i].we) csr_wr(tbl[i].addr, tbl[i].wdata);
      csr_addr_i = tbl[i].addr;
      if (tbl[i].chk_rd) sb_push(tbl[i].name, tbl[i].rd);
      @(negedge clk);
      if (tbl[i].chk_rd) sb_pop(csr_rdata_o);
      chk1({tbl[i].name, "_ill"}, csr_illegal_o, tbl[i].ill);
    end
    csr_rd("nv_mtvec_novec", 1'b1, 12'h305, 32'h0000_1000);

    // MEI latency and interrupt entry with vectored handler
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    irq_ext_i = 1'b1;
    wait_valid(n);
    chk("mei_latency", 32'(n), 32'd3);
    sb_push("mei_mepc_o", 32'h0000_0200);
    sb_push("mei_handler", 32'h0000_102C);
    do_ack(32'h0000_0200);
    sb_pop(mepc_o);
    sb_pop(handler_pc_o);
    chk1("mei_valid_drop", trap_valid_o, 1'b0);
    csr_rd("mei_mcause", 1'b0, 12'h342, 32'h8000_000B);
    csr_rd("mei_mtval", 1'b0, 12'h343, 32'h0);
    csr_rd("mei_mstatus", 1'b0, 12'h300, 32'h0000_1880);

    // MEI beats MTI; MTI taken after mret
    irq_ext_i = 1'b0;
    repeat (3) step();
    csr_wr(12'h304, 32'h0000_0880);
    do_mret();
    csr_rd("mret_mstatus", 1'b0, 12'h300, 32'h0000_1888);
    irq_ext_i = 1'b1;
    irq_timer_i = 1'b1;
    wait_valid(n);
    chk1("both_pend", trap_valid_o, 1'b1);
    do_ack(32'h0000_0300);
    csr_rd("both_mcause", 1'b0, 12'h342, 32'h8000_000B);
    irq_ext_i = 1'b0;
    repeat (3) step();
    do_mret();
    wait_valid(n);
    chk1("mti_pend", trap_valid_o, 1'b1);
    sb_push("mti_handler", 32'h0000_101C);
    do_ack(32'h0000_0304);
    sb_pop(handler_pc_o);
    csr_rd("mti_mcause", 1'b0, 12'h342, 32'h8000_0007);
    csr_rd("mti_mepc", 1'b0, 12'h341, 32'h0000_0304);

    // exception pre-empts a pending MSI
    irq_timer_i = 1'b0;
    repeat (3) step();
    csr_wr(12'h304, 32'h0000_0008);
    do_mret();
    irq_soft_i = 1'b1;
    wait_valid(n);
    chk1("msi_pend", trap_valid_o, 1'b1);
    exc_valid_i = 1'b1;
    exc_code_i  = 5'd2;
    exc_pc_i    = 32'h0000_0400;
    exc_tval_i  = 32'h0000_BAD0;
    sb_push("exc_handler", 32'h0000_1000);
    step();
    exc_valid_i = 1'b0;
    chk1("exc_valid_drop", trap_valid_o, 1'b0);
    sb_pop(handler_pc_o);
    csr_rd("exc_mcause", 1'b0, 12'h342, 32'h0000_0002);
    csr_rd("exc_mtval", 1'b0, 12'h343, 32'h0000_BAD0);
    csr_rd("exc_mepc", 1'b0, 12'h341, 32'h0000_0400);
    csr_rd("exc_mstatus", 1'b0, 12'h300, 32'h0000_1880);

    // ack while in RUN does nothing
    trap_ack_i = 1'b1;
    epc_i = 32'h0000_0999;
    step();
    trap_ack_i = 1'b0;
    csr_rd("ack_run_mepc", 1'b0, 12'h341, 32'h0000_0400);
    chk1("ack_run_valid", trap_valid_o, 1'b0);

    // two custom sources: lower index wins
    irq_soft_i = 1'b0;
    repeat (3) step();
    csr_wr(12'h304, 32'h0003_0000);
    do_mret();
    irq_custom_i = 4'b0011;
    wait_valid(n);
    chk1("cust_pend", trap_valid_o, 1'b1);
    sb_push("cust_handler", 32'h0000_1040);
    do_ack(32'h0000_0500);
    sb_pop(handler_pc_o);
    csr_rd("cust_mcause", 1'b0, 12'h342, 32'h8000_0010);
    irq_custom_i = 4'b0000;
    repeat (3) step();

    // mip reflects inputs and ignores writes
    irq_timer_i = 1'b1;
    repeat (3) step();
    csr_wr(12'h344, 32'hFFFF_FFFF);
    csr_rd("mip_timer", 1'b0, 12'h344, 32'h0000_0080);
    irq_timer_i = 1'b0;
    repeat (3) step();

    // mtvec WARL without vectoring
    csr_wr(12'h305, 32'h0000_0003);
    csr_rd("nv_mtvec_3", 1'b1, 12'h305, 32'h0);
    csr_wr(12'h305, 32'h8000_0101);
    csr_rd("nv_mtvec_1", 1'b1, 12'h305, 32'h8000_0100);
    csr_rd("v_mtvec_1", 1'b0, 12'h305, 32'h8000_0101);

    // asynchronous reset while a trap is requested
    csr_wr(12'h340, 32'h1234_5678);
    csr_wr(12'h304, 32'h0000_0800);
    csr_wr(12'h300, 32'h0000_0008);
    irq_ext_i = 1'b1;
    wait_valid(n);
    chk1("pre_rst_valid", trap_valid_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst_async_valid", trap_valid_o, 1'b0);
    chk("rst_async_mepc_o", mepc_o, 32'h0);
    csr_rd("rst_mstatus2", 1'b0, 12'h300, 32'h0000_1800);
    csr_rd("rst_mtvec2", 1'b0, 12'h305, 32'h0);
    csr_rd("rst_mie2", 1'b0, 12'h304, 32'h0);
    csr_rd("rst_mscratch2", 1'b0, 12'h340, 32'h0);
    csr_rd("rst_mcause2", 1'b0, 12'h342, 32'h0);
    csr_rd("rst_mtval2", 1'b0, 12'h343, 32'h0);
    csr_rd("rst_mip2", 1'b0, 12'h344, 32'h0);
    csr_rd("rst_nv_mtvec2", 1'b1, 12'h305, 32'h8000_0100);
    irq_ext_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk1("post_rst_valid", trap_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
